reg_file_32: RTL



---
 rtl/reg_file_32_pkg.sv | 8 +
 rtl/reg_file_32_if.sv | 29 ++
 rtl/reg_file_32_read_port.sv | 29 ++
 rtl/reg_file_32.sv | 74 +++++++
 4 files changed

// File: rtl/reg_file_32_pkg.sv
// Shared register-file constants: default widths and the hardwired zero register.
package reg_file_32_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned ZERO_REG  = 0;

endpackage : reg_file_32_pkg

// File: rtl/reg_file_32_if.sv
// Register-file bus: two operand read ports, one write port, one debug read port.
interface reg_file_32_if
  import reg_file_32_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) ();

  logic [ADDR_W-1:0] ra_addr;
  logic [DATA_W-1:0] ra_data;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output ra_addr, rb_addr, we, wr_addr, wr_data, dbg_addr,
    input  ra_data, rb_data, dbg_data
  );

  modport slave (
    input  ra_addr, rb_addr, we, wr_addr, wr_data, dbg_addr,
    output ra_data, rb_data, dbg_data
  );

endinterface : reg_file_32_if

// File: rtl/reg_file_32_read_port.sv
// One combinational read path: zero-register check plus optional write-data forwarding.
module rf_read_port
  import reg_file_32_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
  input  logic              byp_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_c
);

  // Address 0 always reads zero; a matching in-flight write wins over storage when bypassing.
  always_comb begin
    rd_data_c = '0;
    if (rd_addr_i != ADDR_W'(ZERO_REG)) begin
      if (BYPASS && byp_en_i && (rd_addr_i == wr_addr_i)) begin
        rd_data_c = wr_data_i;
      end else begin
        rd_data_c = mem_i[rd_addr_i];
      end
    end
  end

endmodule : rf_read_port

// File: rtl/reg_file_32.sv
// 32x32 general-purpose register file: two operand read ports, one write port, debug read.
module reg_file_32
  import reg_file_32_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_32_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] mem_c  [DEPTH];
  logic              wr_en_c;
  logic              byp_en_c;

  // Writes to the zero register are dropped; forwarding is suppressed while in reset.
  always_comb begin
    wr_en_c  = bus.we && (bus.wr_addr != ADDR_W'(ZERO_REG));
    byp_en_c = wr_en_c && rst_n;
  end

  // Storage with asynchronous clear; kept as flops so the clear can be immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Full-depth view of storage with entry 0 pinned to zero.
  always_comb begin
    mem_c[0] = '0;
    for (int i = 1; i < int'(DEPTH); i++) begin
      mem_c[i] = regs_q[i];
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_a (
    .rd_addr_i (bus.ra_addr),
    .mem_i     (mem_c),
    .byp_en_i  (byp_en_c),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_data_c (bus.ra_data)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_b (
    .rd_addr_i (bus.rb_addr),
    .mem_i     (mem_c),
    .byp_en_i  (byp_en_c),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_data_c (bus.rb_data)
  );

  // Debug view always shows committed storage.
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_port_dbg (
    .rd_addr_i (bus.dbg_addr),
    .mem_i     (mem_c),
    .byp_en_i  (1'b0),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_data_c (bus.dbg_data)
  );

endmodule : reg_file_32
